// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_ctrl_pkg : shared types and encodings for the multicycle sequencer  |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CLS_ALU = 2'd0,
    CLS_LW  = 2'd1,
    CLS_SW  = 2'd2,
    CLS_BEQ = 2'd3
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam int         ALU_CODE_W = 4;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef struct packed {
    logic                  reg_dst;
    logic                  alu_src;
    logic                  mem_to_reg;
    logic [ALU_CODE_W-1:0] alu_ctrl;
    instr_class_t          cls;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_seq_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_seq_ctrl_if : instruction handshake and memory strobe bundle  |
// | Revision               : 1.0                                             |
// +--------------------------------------------------------------------------+
interface multicycle_seq_ctrl_if #(
  parameter int INSTR_W = 32
) ();

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instrword;
  logic               mem_ready;
  logic               mem_read;
  logic               mem_write;

  modport master (
    output instr_valid, instrword, mem_ready,
    input  instr_ready, mem_read, mem_write
  );

  modport slave (
    input  instr_valid, instrword, mem_ready,
    output instr_ready, mem_read, mem_write
  );

endinterface
`default_nettype wire

// File: rtl/mips_ctrl_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_ctrl_decode : opcode/funct to datapath control bundle + legal flag  |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  wire logic [5:0] i_opcode,
  input  wire logic [5:0] i_funct,
  output ctrl_t           o_ctrl,
  output logic            o_legal
);

  always_comb begin
    o_ctrl  = '0;
    o_legal = 1'b1;
    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl.reg_dst = 1'b1;
        o_ctrl.cls     = CLS_ALU;
        case (i_funct)
          FN_ADD:  o_ctrl.alu_ctrl = ALU_ADD;
          FN_SUB:  o_ctrl.alu_ctrl = ALU_SUB;
          FN_AND:  o_ctrl.alu_ctrl = ALU_AND;
          FN_OR:   o_ctrl.alu_ctrl = ALU_OR;
          FN_SLT:  o_ctrl.alu_ctrl = ALU_SLT;
          default: o_legal         = 1'b0;
        endcase
      end
      OP_LW: begin
        o_ctrl.alu_ctrl   = ALU_ADD;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.cls        = CLS_LW;
      end
      OP_SW: begin
        o_ctrl.alu_ctrl = ALU_ADD;
        o_ctrl.alu_src  = 1'b1;
        o_ctrl.cls      = CLS_SW;
      end
      OP_ADDI: begin
        o_ctrl.alu_ctrl = ALU_ADD;
        o_ctrl.alu_src  = 1'b1;
        o_ctrl.cls      = CLS_ALU;
      end
      OP_BEQ: begin
        o_ctrl.alu_ctrl = ALU_SUB;
        o_ctrl.cls      = CLS_BEQ;
      end
      default: o_legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_seq_ctrl : multicycle IDLE/ID/EX/MEM/WB instruction sequencer |
// | Optional perf counters enabled by defining MULTICYCLE_PERF_EN.           |
// | Revision            : 1.0                                                |
// +--------------------------------------------------------------------------+
module multicycle_seq_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int INSTR_W      = 32,
  parameter int ALUCTRL_W    = 4,
  parameter int MEM_WAIT_MAX = 8,
  parameter int RETIRE_W     = 16
) (
  input  wire logic              clock,
  input  wire logic              reset,
  multicycle_seq_ctrl_if.slave   bus,
  input  wire logic              alu_zero,
  output logic                   reg_dst,
  output logic                   alu_src,
  output logic                   mem_to_reg,
  output logic [ALUCTRL_W-1:0]   alu_ctrl,
  output logic                   reg_write,
  output logic                   branch_taken,
  output logic                   retire,
  output logic                   illegal_op,
  output logic                   mem_err,
`ifdef MULTICYCLE_PERF_EN
  output logic [RETIRE_W-1:0]    retired_count,
  output logic [31:0]            cycle_count,
  output logic [31:0]            stall_count
`else
  output logic [RETIRE_W-1:0]    retired_count
`endif
);

  localparam int c_WAIT_W = $clog2(MEM_WAIT_MAX + 1);

  state_t                r_state;
  state_t                w_state_nxt;
  instr_class_t          r_cls;
  logic                  r_legal;
  logic                  r_reg_dst;
  logic                  r_alu_src;
  logic                  r_mem_to_reg;
  logic [ALUCTRL_W-1:0]  r_alu_ctrl;
  logic [c_WAIT_W-1:0]   r_wait;
  logic [RETIRE_W-1:0]   r_retired;

  ctrl_t                 w_dec;
  logic                  w_dec_legal;
  logic                  w_accept;
  logic                  w_wait_done;
  logic                  w_instr_ready;
  logic                  w_mem_read;
  logic                  w_mem_write;
  logic                  w_reg_write;
  logic                  w_branch_taken;
  logic                  w_retire;
  logic                  w_illegal_op;
  logic                  w_mem_err;
  logic                  w_unused_instr;

  mips_ctrl_decode u_decode (
    .i_opcode (bus.instrword[31:26]),
    .i_funct  (bus.instrword[5:0]),
    .o_ctrl   (w_dec),
    .o_legal  (w_dec_legal)
  );

  // Only opcode and funct fields steer the sequencer; fold the rest away.
  assign w_unused_instr = ^bus.instrword[INSTR_W-1:0];

  assign w_accept    = (r_state == ST_IDLE) && bus.instr_valid;
  assign w_wait_done = (r_wait >= c_WAIT_W'(MEM_WAIT_MAX));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_instr_ready  = 1'b0;
    w_mem_read     = 1'b0;
    w_mem_write    = 1'b0;
    w_reg_write    = 1'b0;
    w_branch_taken = 1'b0;
    w_retire       = 1'b0;
    w_illegal_op   = 1'b0;
    w_mem_err      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_instr_ready = 1'b1;
        if (bus.instr_valid) begin
          w_state_nxt = ST_ID;
        end
      end
      ST_ID: begin
        if (r_legal) begin
          w_state_nxt = ST_EX;
        end else begin
          w_illegal_op = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_EX: begin
        case (r_cls)
          CLS_BEQ: begin
            w_branch_taken = alu_zero;
            w_retire       = 1'b1;
            w_state_nxt    = ST_IDLE;
          end
          CLS_LW, CLS_SW: w_state_nxt = ST_MEM;
          default:        w_state_nxt = ST_WB;
        endcase
      end
      ST_MEM: begin
        w_mem_read  = (r_cls == CLS_LW);
        w_mem_write = (r_cls == CLS_SW);
        // A ready on the final permitted wait cycle still completes the access.
        if (bus.mem_ready) begin
          if (r_cls == CLS_LW) begin
            w_state_nxt = ST_WB;
          end else begin
            w_retire    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else if (w_wait_done) begin
          w_mem_err   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Controls are decoded off the accepted word so they are already stable in ID.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cls        <= CLS_ALU;
      r_legal      <= 1'b0;
      r_reg_dst    <= 1'b0;
      r_alu_src    <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_ctrl   <= '0;
    end else if (w_accept) begin
      r_cls   <= w_dec.cls;
      r_legal <= w_dec_legal;
      if (w_dec_legal) begin
        r_reg_dst    <= w_dec.reg_dst;
        r_alu_src    <= w_dec.alu_src;
        r_mem_to_reg <= w_dec.mem_to_reg;
        r_alu_ctrl   <= ALUCTRL_W'(w_dec.alu_ctrl);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wait <= '0;
    end else if (r_state == ST_EX) begin
      r_wait <= c_WAIT_W'(1);
    end else if (r_state == ST_MEM) begin
      r_wait <= r_wait + c_WAIT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + RETIRE_W'(1);
    end
  end

`ifdef MULTICYCLE_PERF_EN
  logic [31:0] r_cycle_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cycle_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (r_state != ST_IDLE) begin
        r_cycle_count <= r_cycle_count + 32'd1;
      end
      if ((r_state == ST_MEM) && !bus.mem_ready) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign cycle_count = r_cycle_count;
  assign stall_count = r_stall_count;
`endif

  assign bus.instr_ready = w_instr_ready;
  assign bus.mem_read    = w_mem_read;
  assign bus.mem_write   = w_mem_write;
  assign reg_dst         = r_reg_dst;
  assign alu_src         = r_alu_src;
  assign mem_to_reg      = r_mem_to_reg;
  assign alu_ctrl        = r_alu_ctrl;
  assign reg_write       = w_reg_write;
  assign branch_taken    = w_branch_taken;
  assign retire          = w_retire;
  assign illegal_op      = w_illegal_op;
  assign mem_err         = w_mem_err;
  assign retired_count   = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multicycle_seq_ctrl : directed scoreboard bench for the sequencer     |
// | Revision               : 1.0                                             |
// +--------------------------------------------------------------------------+
module tb_multicycle_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_zero;
  logic        reg_dst, alu_src, mem_to_reg;
  logic [3:0]  alu_ctrl;
  logic        reg_write, branch_taken, retire, illegal_op, mem_err;
  logic [15:0] retired_count;
`ifdef MULTICYCLE_PERF_EN
  logic [31:0] cycle_count, stall_count;
`endif

  int errors = 0;
  int checks = 0;
  int model_retired = 0;

  always #5 clock = ~clock;

  multicycle_seq_ctrl_if #(.INSTR_W(32)) bus ();

  multicycle_seq_ctrl #(
    .INSTR_W      (32),
    .ALUCTRL_W    (4),
    .MEM_WAIT_MAX (8),
    .RETIRE_W     (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus.slave),
    .alu_zero      (alu_zero),
    .reg_dst       (reg_dst),
    .alu_src       (alu_src),
    .mem_to_reg    (mem_to_reg),
    .alu_ctrl      (alu_ctrl),
    .reg_write     (reg_write),
    .branch_taken  (branch_taken),
    .retire        (retire),
    .illegal_op    (illegal_op),
    .mem_err       (mem_err),
`ifdef MULTICYCLE_PERF_EN
    .retired_count (retired_count),
    .cycle_count   (cycle_count),
    .stall_count   (stall_count)
`else
    .retired_count (retired_count)
`endif
  );

  // Event cycles are counted from the accept edge; 0 means the event never happened.
  typedef struct packed {
    logic [31:0] ctrl;
    logic [31:0] rw;
    logic [31:0] rt;
    logic [31:0] br;
    logic [31:0] err;
    logic [31:0] ill;
    logic [31:0] nrd;
    logic [31:0] nwr;
    logic [31:0] rdy;
  } rec_t;

  rec_t  exp_q[$];
  string tag_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic rec_t mk(input int ctrl, input int rw, input int rt, input int br,
                              input int err, input int ill, input int nrd, input int nwr,
                              input int rdy);
    rec_t r;
    r.ctrl = ctrl; r.rw = rw; r.rt = rt; r.br = br; r.err = err;
    r.ill = ill; r.nrd = nrd; r.nwr = nwr; r.rdy = rdy;
    return r;
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] funct);
    return {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op);
    return {op, 5'd4, 5'd5, 16'h0010};
  endfunction

  // Called at a falling edge with the sequencer idle; returns at the falling edge
  // on which instr_ready comes back, so the next call issues back-to-back.
  task automatic run_instr(input string tag, input logic [31:0] word, input int ready_at,
                           input logic az, input rec_t e);
    rec_t o;
    rec_t x;
    string t;
    int mcnt;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (e.rt != 0) model_retired++;
    check({tag, ".ready_in"}, {31'd0, bus.instr_ready}, 32'd1);
    bus.instr_valid = 1'b1;
    bus.instrword   = word;
    alu_zero        = az;
    @(posedge clock);
    #1;
    // Keep valid high with junk while busy: it must be ignored.
    bus.instrword = $urandom;
    o    = '0;
    mcnt = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (bus.mem_read || bus.mem_write) mcnt++;
      bus.mem_ready = (ready_at != 0) && (mcnt == ready_at);
      @(negedge clock);
      if (cyc == 1) o.ctrl = {25'd0, reg_dst, alu_src, mem_to_reg, alu_ctrl};
      if (reg_write && o.rw == 0) o.rw = cyc;
      if (retire && o.rt == 0) o.rt = cyc;
      if (branch_taken) o.br = o.br + 1;
      if (mem_err && o.err == 0) o.err = cyc;
      if (illegal_op && o.ill == 0) o.ill = cyc;
      if (bus.mem_read) o.nrd = o.nrd + 1;
      if (bus.mem_write) o.nwr = o.nwr + 1;
      if (bus.instr_ready) begin
        o.rdy = cyc;
        break;
      end
      @(posedge clock);
      #1;
    end
    bus.instr_valid = 1'b0;
    bus.mem_ready   = 1'b0;
    x = exp_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".ctrl"},  o.ctrl, x.ctrl);
    check({t, ".rw"},    o.rw,   x.rw);
    check({t, ".rt"},    o.rt,   x.rt);
    check({t, ".br"},    o.br,   x.br);
    check({t, ".err"},   o.err,  x.err);
    check({t, ".ill"},   o.ill,  x.ill);
    check({t, ".nrd"},   o.nrd,  x.nrd);
    check({t, ".nwr"},   o.nwr,  x.nwr);
    check({t, ".rdy"},   o.rdy,  x.rdy);
    check({t, ".count"}, {16'd0, retired_count}, model_retired);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrw;
    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instrword   = '0;
    bus.mem_ready   = 1'b0;
    alu_zero        = 1'b0;
    #1;
    check("rst.ready",    {31'd0, bus.instr_ready}, 32'd1);
    check("rst.count",    {16'd0, retired_count},   32'd0);
    check("rst.alu_ctrl", {28'd0, alu_ctrl},        32'd0);
    check("rst.strobes",  {26'd0, bus.mem_read, bus.mem_write, reg_write, retire,
                           illegal_op, mem_err},    32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // ctrl = {reg_dst, alu_src, mem_to_reg, alu_ctrl[3:0]}
    run_instr("add",     rtype(6'd32), 0, 1'b0, mk('h42, 3, 3, 0, 0, 0, 0, 0, 4));
    run_instr("lw_w3",   itype(6'd35), 3, 1'b0, mk('h32, 6, 6, 0, 0, 0, 3, 0, 7));
    run_instr("sw_to",   itype(6'd43), 0, 1'b0, mk('h22, 0, 0, 0, 10, 0, 0, 8, 11));
    run_instr("beq_z1",  itype(6'd4),  0, 1'b1, mk('h06, 0, 2, 1, 0, 0, 0, 0, 3));
    run_instr("beq_z0",  itype(6'd4),  0, 1'b0, mk('h06, 0, 2, 0, 0, 0, 0, 0, 3));
    run_instr("op63",    itype(6'd63), 0, 1'b0, mk('h06, 0, 0, 0, 0, 1, 0, 0, 2));
    run_instr("fn9",     rtype(6'd9),  0, 1'b0, mk('h06, 0, 0, 0, 0, 1, 0, 0, 2));
    run_instr("sw_w1",   itype(6'd43), 1, 1'b0, mk('h22, 0, 3, 0, 0, 0, 0, 1, 4));
    run_instr("lw_wmax", itype(6'd35), 8, 1'b0, mk('h32, 11, 11, 0, 0, 0, 8, 0, 12));
    run_instr("sub",     rtype(6'd34), 0, 1'b1, mk('h46, 3, 3, 0, 0, 0, 0, 0, 4));
    run_instr("and",     rtype(6'd36), 0, 1'b0, mk('h40, 3, 3, 0, 0, 0, 0, 0, 4));
    run_instr("or",      rtype(6'd37), 0, 1'b0, mk('h41, 3, 3, 0, 0, 0, 0, 0, 4));
    run_instr("slt",     rtype(6'd42), 0, 1'b0, mk('h47, 3, 3, 0, 0, 0, 0, 0, 4));
    run_instr("addi",    itype(6'd8),  0, 1'b0, mk('h22, 3, 3, 0, 0, 0, 0, 0, 4));

    // Reset in the middle of a lw memory wait.
    bus.instr_valid = 1'b1;
    bus.instrword   = itype(6'd35);
    @(posedge clock);
    #1;
    bus.instr_valid = 1'b0;
    bus.mem_ready   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("mid.mem_read", {31'd0, bus.mem_read}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid.rst_mem_read", {31'd0, bus.mem_read},    32'd0);
    check("mid.rst_ready",    {31'd0, bus.instr_ready}, 32'd1);
    check("mid.rst_count",    {16'd0, retired_count},   32'd0);
    check("mid.rst_alu_ctrl", {28'd0, alu_ctrl},        32'd0);
    @(negedge clock);
    reset = 1'b0;
    nrw   = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (reg_write || retire) nrw++;
    end
    check("mid.no_wb", nrw, 32'd0);
    check("mid.idle",  {31'd0, bus.instr_ready}, 32'd1);
    model_retired = 0;
    run_instr("add_post", rtype(6'd32), 0, 1'b0, mk('h42, 3, 3, 0, 0, 0, 0, 0, 4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
